friscv_scfifo: RTL
==================

Name: friscv_scfifo

Overview:
Single-clock FIFO controller with valid/ready handshakes on both sides. It owns the write and read pointers, the full/empty logic and the occupancy count. It drives the team's asynchronous-read dual-port RAM primitive, friscv_scfifo_ram, which is instantiated inside this block. The block is the standard elastic buffer used between pipeline stages, for example fetch-to-decode and the AXI response paths.

Parameters:
- PASS_THRU, 0: runtime-constant mirror of the optional feature. Ignored unless the macro is defined.
- ADDR_WIDTH, 8: log2 of the FIFO depth. Depth = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8: payload width in bits.
- AFULL_THRESH, 2**ADDR_WIDTH-1: count at or above which afull asserts.

Ports:
- aclk  in  1  clock. All logic is on the rising edge.
- srst  in  1  synchronous reset, active-high.
- in_valid  in  1  write request.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  DATA_WIDTH  write payload.
- out_valid  out  1  a word is available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_WIDTH  head-of-FIFO payload.
- count  out  ADDR_WIDTH+1  current occupancy, 0 to 2**ADDR_WIDTH.
- full  out  1  count == 2**ADDR_WIDTH.
- empty  out  1  count == 0.
- afull  out  1  count >= AFULL_THRESH.

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are each ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the RAM; the MSB is the wrap bit.
  - empty when wr_ptr == rd_ptr.
  - full when the address bits are equal and the MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1). Registered pointers, combinational count.
- Write:
  - in_ready = !full && !srst.
  - Push when in_valid && in_ready: RAM written at wr_ptr[ADDR_WIDTH-1:0], wr_ptr increments.
- Read:
  - out_valid = !empty && !srst.
  - out_data = RAM[rd_ptr] (combinational).
  - Pop when out_valid && out_ready: rd_ptr increments.
- Latency: a word written in cycle N is visible on out_data/out_valid in cycle N+1 (non-pass-through).
- Simultaneous push and pop:
  - Both occur in the same cycle; count is unchanged.
  - When full, push is blocked by in_ready=0; pop is still allowed, so in_ready rises the next cycle. No same-cycle write-through of a freed slot.
  - When empty, pop is blocked; the push lands and out_valid rises the next cycle.
- Wrap-around: pointers roll over naturally. There is no special handling at 2**(ADDR_WIDTH+1)-1 → 0.
- Handshake rules:
  - Producer must hold in_data stable while in_valid && !in_ready. The FIFO never depends on in_valid dropping.
  - out_data is stable while out_valid && !out_ready.
- Reset:
  - On the srst edge: wr_ptr = rd_ptr = 0, so count=0, empty=1, full=0, afull=0 (AFULL_THRESH ≥ 1).
  - While srst is high: in_ready=0, out_valid=0.
  - Reset mid-operation discards all contents.
  - RAM contents are not cleared; they are unreachable after reset.
- Illegal parameter: AFULL_THRESH outside 1..2**ADDR_WIDTH is rejected by an elaboration-time check.

Optional Feature:
Macro: FRISCV_SCFIFO_PASS_THRU_EN
- Defined, and PASS_THRU=1:
  - When empty && in_valid, the block drives out_valid=1 and out_data=in_data combinationally in the same cycle.
  - If out_ready is also high, the word is consumed directly: no RAM write, pointers unchanged.
  - If out_ready is low, a normal push occurs.
  - in_ready is unchanged.
- Undefined: pass-through logic is absent. Behaviour is exactly as above, with 1-cycle minimum latency.

Decomposition:
- Shared package friscv_scfifo_pkg holds:
  - function clog2-safe depth helper;
  - localparam for pointer width derivation, ADDR_WIDTH+1.
- No typedefs are required. The payload stays a flat vector.
- One sub-module: friscv_scfifo_ram (write port driven by the push, read address = rd_ptr[ADDR_WIDTH-1:0]).
- All control lives in friscv_scfifo.

Test Plan:
Bench configuration: ADDR_WIDTH=2 (depth 4), DATA_WIDTH=8, AFULL_THRESH=3, macro undefined unless stated.
1. Reset then idle → in_ready=1, out_valid=0, empty=1, count=0. With srst high and in_valid=1 → no push, count stays 0.
2. Push 0x11,0x22,0x33,0x44 with out_ready=0 → count goes 1,2,3,4; afull at count=3; full=1 and in_ready=0 after the 4th. A 5th push of 0x55 is ignored.
3. From full, pop 4 with out_ready=1 → out_data is 0x11,0x22,0x33,0x44 in order; empty=1 after. A write issued during the pop in which the FIFO is full is blocked.
4. Continuous stream of 20 words 0x00..0x13 with in_valid=out_ready=1 → pointers wrap ≥ 4 times, output sequence matches input, count stays ≤ 1.
5. Fill to 2 entries, assert srst for 1 cycle mid-stream → count=0, out_valid=0 next cycle. A subsequent push of 0xA5 is read back as 0xA5.
6. With FRISCV_SCFIFO_PASS_THRU_EN defined and PASS_THRU=1, empty FIFO, in_valid=1, in_data=0x5A, out_ready=1 → same-cycle out_valid=1, out_data=0x5A, count remains 0.

Source files
------------

// File: rtl/friscv_scfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : friscv_scfifo_pkg
// Description : Shared sizing helpers for the single-clock FIFO and its RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package friscv_scfifo_pkg;

    // One extra pointer bit tells full apart from empty.
    localparam int unsigned c_ptr_extra_bits = 1;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned addr_w);
        return addr_w + c_ptr_extra_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/friscv_scfifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : friscv_scfifo_ram
// Description : Dual-port RAM, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module friscv_scfifo_ram
    import friscv_scfifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int c_depth = int'(fifo_depth(ADDR_WIDTH));

    // No reset: stale entries are unreachable once the pointers are cleared.
    logic [DATA_WIDTH-1:0] mem_q [0:c_depth-1];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/friscv_scfifo.sv
`default_nettype none
// ============================================================================
// Module      : friscv_scfifo
// Description : Single-clock valid/ready FIFO controller around an
//               asynchronous-read RAM. Optional same-cycle pass-through when
//               empty is enabled by macro FRISCV_SCFIFO_PASS_THRU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module friscv_scfifo
    import friscv_scfifo_pkg::*;
#(
    parameter int PASS_THRU    = 0,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH-1
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  afull
);

    localparam int c_ptr_w = int'(ptr_width(ADDR_WIDTH));
    localparam int c_depth = int'(fifo_depth(ADDR_WIDTH));
    localparam logic [c_ptr_w-1:0] c_afull = c_ptr_w'(AFULL_THRESH);

    generate
        if (AFULL_THRESH < 1 || AFULL_THRESH > c_depth) begin : g_bad_afull
            $error("friscv_scfifo: AFULL_THRESH must lie in 1..2**ADDR_WIDTH");
        end
    endgenerate

    logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_ram_valid;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_empty     = (wr_ptr_q == rd_ptr_q);
    assign w_full      = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                         (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign w_ram_valid = !w_empty && !srst;

`ifdef FRISCV_SCFIFO_PASS_THRU_EN
    // Empty FIFO forwards the producer word straight to the consumer.
    assign w_bypass = (PASS_THRU != 0) && w_empty && in_valid && !srst;
`else
    assign w_bypass = 1'b0;
    generate
        if (PASS_THRU != 0) begin : g_pass_thru_ignored
        end
    endgenerate
`endif

    assign in_ready  = !w_full && !srst;
    assign out_valid = w_ram_valid || w_bypass;
    assign out_data  = w_bypass ? in_data : w_ram_rdata;

    // A bypassed word that is consumed immediately never touches the RAM.
    assign w_push = in_valid && in_ready && !(w_bypass && out_ready);
    assign w_pop  = w_ram_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = w_full;
    assign empty = w_empty;
    assign afull = (count >= c_afull);

    friscv_scfifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i     (aclk),
        .wr_en_i   (w_push),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (w_ram_rdata)
    );

endmodule
`default_nettype wire
